spi_master_multi: RTL and testbench
===================================

Name: spi_master_multi

Overview:
Parametrised next-generation SPI master. It supports configurable word width, N chip-selects, a programmable SCLK divider, all four CPOL/CPHA modes selectable per transfer, and MSB- or LSB-first ordering. It sits between a local controller, which uses a start/done handshake, and one or more off-chip SPI slaves sharing SCLK, MOSI and MISO.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
NUM_SLAVES, 4, number of chip-select lines (>=1)
SEL_W, 2, width of slave_sel; 2**SEL_W >= NUM_SLAVES
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  transfer request, sampled only in IDLE
cpol  in  1  SCLK idle level for the transfer
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first  in  1  1: LSB shifted first; 0: MSB first
slave_sel  in  SEL_W  index of CS line to assert
data_in  in  DATA_WIDTH  word to transmit
data_out  out  DATA_WIDTH  last received word
busy  out  1  high from start-accept until done cycle inclusive
done  out  1  one-cycle completion pulse
SCLK  out  1  serial clock
MOSI  out  1  serial data out
MISO  in  1  serial data in
CS  out  NUM_SLAVES  active-low chip selects

Behaviour:
- Reset (rst=0, async): state IDLE, CS all 1, SCLK 0, MOSI 0, data_out 0, busy 0, done 0, counters 0. Reset mid-transfer aborts immediately; no done pulse.
- IDLE: SCLK registers cpol every cycle. On clk edge with start=1, the block latches data_in, cpol, cpha, lsb_first and slave_sel into the shift and mode registers (start-accept edge, T0), sets busy=1, and goes to LEAD.
- LEAD (CLK_DIV cycles): CS[sel]=0 from T0+1. MOSI = first bit (data_in[DW-1] if MSB-first, else [0]). SCLK = cpol.
- XFER: 2*DATA_WIDTH half-periods of CLK_DIV cycles each; SCLK toggles at every half-period boundary, starting at the end of LEAD. Edges alternate leading (away from cpol) and trailing, and there are exactly DATA_WIDTH leading edges.
  - cpha=0: MISO sampled into the shift register on each leading edge; MOSI advances to the next bit on each trailing edge except the last.
  - cpha=1: MOSI advances on each leading edge (first leading edge presents bit 0 of the order); MISO sampled on each trailing edge.
  - Received bits fill in transmit order: MSB-first fills from bit DW-1 downward, LSB-first from bit 0 upward.
- TRAIL (CLK_DIV cycles): SCLK = cpol, CS held low.
- The edge ending TRAIL sets CS all 1, data_out = received word, done=1 for one cycle, then returns to IDLE. busy drops the cycle after done.
- CS[sel] is low for exactly (2*DATA_WIDTH+2)*CLK_DIV clk cycles. done is high in the first cycle CS is high again.
- MOSI holds its last bit after a transfer until the next start-accept.
- start while busy is ignored, with no queuing. start in the done cycle is ignored; start in the following cycle is accepted.
- slave_sel >= NUM_SLAVES: transfer runs with full timing but CS stays all 1; done still pulses; data_out captures MISO.
- Only the selected CS bit ever goes low; the others stay 1.
- Inputs other than start are don't-care while busy; changing them has no effect on the transfer in progress.
- data_out is unchanged except on the done edge.

Test Plan:
- DW=8, CLK_DIV=2, mode 0, MSB-first, sel=0, data_in=0xA5, slave model returns 0x3C -> slave receives 0xA5; data_out=0x3C on done; CS[0] low for 36 clk cycles; 8 rising SCLK edges.
- Repeat 0xA5/0x3C in modes 1, 2 and 3 against a mode-matched slave model -> correct exchange in each mode; SCLK idles at cpol before and after.
- lsb_first=1, data_in=0x01, slave returns 0x80 -> first MOSI bit is 1; data_out=0x80; slave (LSB-first) receives 0x01.
- NUM_SLAVES=4: sel=2 then sel=5 (SEL_W=3 build) -> first transfer drives only CS[2] low; second keeps CS=4'hF, done still pulses.
- start pulsed again at mid-transfer and in the done cycle -> both ignored; exactly one done per accepted start; start one cycle after done is accepted.
- rst driven low during the 4th bit -> CS=all 1, SCLK=0, busy=0, no done; next transfer after reset release is correct.

Source files
------------

// File: rtl/spi_master_multi.sv
// SPI master with N chip-selects, programmable SCLK divider,
// per-transfer CPOL/CPHA and MSB/LSB-first ordering.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; SCLK follows cpol, CS all high
//   S_LEAD  | CS asserted, first MOSI bit presented, SCLK at idle level
//   S_XFER  | 2*DATA_WIDTH SCLK half-periods, shifting in/out
//   S_TRAIL | SCLK back at idle level, CS still asserted before release
module spi_master_multi #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2,
    parameter int CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic [NUM_SLAVES-1:0] CS
);

    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);
    localparam logic [EDGE_W-1:0] EDGE_PEN  = EDGE_W'(2 * DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_MSB   = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_XFER,
        S_TRAIL
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [EDGE_W-1:0]       edge_q, edge_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [IDX_W-1:0]        txi_q, txi_d;
    logic [IDX_W-1:0]        rxi_q, rxi_d;
    logic                    cpha_q, cpha_d;
    logic                    lsb_q, lsb_d;
    logic                    sclk_q, sclk_d;
    logic                    mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0]   cs_q, cs_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    fire;
    logic                    lead;
    logic                    do_sample;
    logic                    do_shift;
    logic [IDX_W-1:0]        tx_nxt;
    logic [IDX_W-1:0]        tx_phys;
    logic [IDX_W-1:0]        rx_phys;

    // Sequencing, SCLK edge generation and shift/sample of the serial data.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        txi_d     = txi_q;
        rxi_d     = rxi_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_d      = cs_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fire      = 1'b0;
        lead      = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        tx_nxt    = txi_q + IDX_W'(1);
        tx_phys   = lsb_q ? tx_nxt : (IDX_MSB - tx_nxt);
        rx_phys   = lsb_q ? rxi_q : (IDX_MSB - rxi_q);

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                busy_d = 1'b0;
                // the done cycle is still IDLE but must not accept a new start
                if (start && !done_q) begin
                    state_d = S_LEAD;
                    cnt_d   = CNT_LOAD;
                    edge_d  = '0;
                    txi_d   = '0;
                    rxi_d   = '0;
                    tx_d    = data_in;
                    rx_d    = '0;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    busy_d  = 1'b1;
                    mosi_d  = lsb_first ? data_in[0] : data_in[DATA_WIDTH-1];
                    for (int i = 0; i < NUM_SLAVES; i++) begin
                        cs_d[i] = (slave_sel != SEL_W'(i));
                    end
                end
            end
            S_LEAD: begin
                if (cnt_q == '0) begin
                    state_d = S_XFER;
                    cnt_d   = CNT_LOAD;
                    fire    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_XFER: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_LOAD;
                    if (edge_q == EDGE_LAST) begin
                        state_d = S_TRAIL;
                    end else begin
                        fire = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_TRAIL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cs_d    = '1;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // odd-numbered edges (edge_q even before the toggle) move SCLK away from cpol
        if (fire) begin
            sclk_d    = ~sclk_q;
            edge_d    = edge_q + EDGE_W'(1);
            lead      = ~edge_q[0];
            do_sample = cpha_q ? ~lead : lead;
            // cpha=1 presents bit 0 before the first leading edge already
            do_shift  = cpha_q ? (lead && (edge_q != '0)) : (!lead && (edge_q != EDGE_PEN));
            if (do_sample) begin
                rx_d[rx_phys] = MISO;
                rxi_d         = rxi_q + IDX_W'(1);
            end
            if (do_shift) begin
                txi_d  = tx_nxt;
                mosi_d = tx_q[tx_phys];
            end
        end
    end

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            txi_q   <= '0;
            rxi_q   <= '0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= '1;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            txi_q   <= txi_d;
            rxi_q   <= rxi_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = dout_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign CS       = cs_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi with a mode-matched slave model.
module tb_spi_master_multi;

    localparam int DW = 8;
    localparam int NS = 4;
    localparam int SW = 3;
    localparam int CD = 2;
    localparam int CS_LOW = (2 * DW + 2) * CD;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cpol;
    logic          cpha;
    logic          lsb_first;
    logic [SW-1:0] slave_sel;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          done;
    logic          SCLK;
    logic          MOSI;
    logic          miso = 1'b0;
    logic [NS-1:0] CS;

    int checks   = 0;
    int failures = 0;

    // slave model configuration (written by tasks) and state (owned by the model)
    bit            s_act = 1'b0;
    bit            s_cpol, s_cpha, s_lsb;
    logic [DW-1:0] s_tx;
    int            s_gen = 0;
    int            s_gen_seen = 0;
    logic [DW-1:0] s_rx;
    int            s_ti, s_ri;

    spi_master_multi #(
        .DATA_WIDTH(DW),
        .NUM_SLAVES(NS),
        .SEL_W(SW),
        .CLK_DIV(CD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cpol(cpol),
        .cpha(cpha),
        .lsb_first(lsb_first),
        .slave_sel(slave_sel),
        .data_in(data_in),
        .data_out(data_out),
        .busy(busy),
        .done(done),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .MISO(miso),
        .CS(CS)
    );

    always #5 clk = ~clk;

    function automatic int pidx(input int i);
        return s_lsb ? i : (DW - 1 - i);
    endfunction

    // SPI slave: samples MOSI and shifts MISO on the edges its mode dictates
    always @(SCLK or s_gen) begin
        if (s_gen != s_gen_seen) begin
            s_gen_seen = s_gen;
            s_rx = '0;
            s_ri = 0;
            if (s_cpha) s_ti = -1;
            else begin
                s_ti = 0;
                miso = s_tx[pidx(0)];
            end
        end else if (s_act) begin
            if ((SCLK !== s_cpol) ^ s_cpha) begin
                if (s_ri < DW) s_rx[pidx(s_ri)] = MOSI;
                s_ri++;
            end else begin
                s_ti++;
                if (s_ti >= 0 && s_ti < DW) miso = s_tx[pidx(s_ti)];
            end
        end
    end

    task automatic arm_slave(input bit pol, input bit pha, input bit lsb, input logic [DW-1:0] ret);
        s_cpol = pol;
        s_cpha = pha;
        s_lsb  = lsb;
        s_tx   = ret;
        s_gen++;
        #1;
        s_act = 1'b1;
    endtask

    task automatic do_xfer(input bit pol, input bit pha, input bit lsb, input logic [SW-1:0] sel,
                           input logic [DW-1:0] din, input logic [DW-1:0] ret,
                           output int cs_low, output int rises, output int dones,
                           output logic [NS-1:0] cs_and, output logic [DW-1:0] dout,
                           output logic [DW-1:0] srx, output logic mosi_first,
                           output logic sclk_before, output logic sclk_after,
                           output logic busy_at_done, output logic busy_after);
        int   cyc;
        logic prev;
        @(negedge clk);
        cpol = pol; cpha = pha; lsb_first = lsb; slave_sel = sel; data_in = din;
        repeat (2) @(negedge clk);
        sclk_before = SCLK;
        arm_slave(pol, pha, lsb, ret);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cs_low = 0; rises = 0; dones = 0; cs_and = '1; dout = 'x; busy_at_done = 1'bx;
        mosi_first = MOSI;
        prev = SCLK;
        cyc = 0;
        while (dones == 0 && cyc < 200) begin
            if (CS !== '1) cs_low++;
            cs_and &= CS;
            if (SCLK === 1'b1 && prev === 1'b0) rises++;
            prev = SCLK;
            if (done === 1'b1) begin
                dones++;
                dout = data_out;
                busy_at_done = busy;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        s_act = 1'b0;
        srx = s_rx;
        @(negedge clk);
        sclk_after = SCLK;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        slave_sel = '0; data_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (CS !== 4'hF) begin failures++; $display("FAIL reset_cs: got %h expected F", CS); end
        checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b expected 0", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", MOSI); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", data_out); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_modes();
        int cs_low, rises, dones;
        logic [NS-1:0] cs_and;
        logic [DW-1:0] dout, srx;
        logic mf, sb, sa, bd, ba;
        for (int m = 0; m < 4; m++) begin
            do_xfer(m[1], m[0], 1'b0, 3'd0, 8'hA5, 8'h3C,
                    cs_low, rises, dones, cs_and, dout, srx, mf, sb, sa, bd, ba);
            checks++; if (dones !== 1) begin failures++; $display("FAIL mode%0d_done: got %0d expected 1", m, dones); end
            checks++; if (dout !== 8'h3C) begin failures++; $display("FAIL mode%0d_dout: got %h expected 3c", m, dout); end
            checks++; if (srx !== 8'hA5) begin failures++; $display("FAIL mode%0d_slave_rx: got %h expected a5", m, srx); end
            checks++; if (cs_low !== CS_LOW) begin failures++; $display("FAIL mode%0d_cs_low: got %0d expected %0d", m, cs_low, CS_LOW); end
            checks++; if (cs_and !== 4'b1110) begin failures++; $display("FAIL mode%0d_cs_and: got %b expected 1110", m, cs_and); end
            checks++; if (rises !== DW) begin failures++; $display("FAIL mode%0d_rises: got %0d expected %0d", m, rises, DW); end
            checks++; if (sb !== m[1] || sa !== m[1]) begin failures++; $display("FAIL mode%0d_sclk_idle: got %b/%b expected %b", m, sb, sa, m[1]); end
            checks++; if (bd !== 1'b1 || ba !== 1'b0) begin failures++; $display("FAIL mode%0d_busy: got %b/%b expected 1/0", m, bd, ba); end
            checks++; if (mf !== 1'b1) begin failures++; $display("FAIL mode%0d_mosi_first: got %b expected 1", m, mf); end
        end
    endtask

    task automatic test_lsb_first();
        int cs_low, rises, dones;
        logic [NS-1:0] cs_and;
        logic [DW-1:0] dout, srx;
        logic mf, sb, sa, bd, ba;
        do_xfer(1'b0, 1'b0, 1'b1, 3'd0, 8'h01, 8'h80,
                cs_low, rises, dones, cs_and, dout, srx, mf, sb, sa, bd, ba);
        checks++; if (mf !== 1'b1) begin failures++; $display("FAIL lsb_mosi_first: got %b expected 1", mf); end
        checks++; if (dout !== 8'h80) begin failures++; $display("FAIL lsb_dout: got %h expected 80", dout); end
        checks++; if (srx !== 8'h01) begin failures++; $display("FAIL lsb_slave_rx: got %h expected 01", srx); end
        do_xfer(1'b1, 1'b1, 1'b1, 3'd0, 8'hC8, 8'h13,
                cs_low, rises, dones, cs_and, dout, srx, mf, sb, sa, bd, ba);
        checks++; if (mf !== 1'b0) begin failures++; $display("FAIL lsb3_mosi_first: got %b expected 0", mf); end
        checks++; if (dout !== 8'h13) begin failures++; $display("FAIL lsb3_dout: got %h expected 13", dout); end
        checks++; if (srx !== 8'hC8) begin failures++; $display("FAIL lsb3_slave_rx: got %h expected c8", srx); end
    endtask

    task automatic test_slave_sel();
        int cs_low, rises, dones;
        logic [NS-1:0] cs_and;
        logic [DW-1:0] dout, srx;
        logic mf, sb, sa, bd, ba;
        do_xfer(1'b0, 1'b0, 1'b0, 3'd2, 8'h7E, 8'hE7,
                cs_low, rises, dones, cs_and, dout, srx, mf, sb, sa, bd, ba);
        checks++; if (cs_and !== 4'b1011) begin failures++; $display("FAIL sel2_cs_and: got %b expected 1011", cs_and); end
        checks++; if (cs_low !== CS_LOW) begin failures++; $display("FAIL sel2_cs_low: got %0d expected %0d", cs_low, CS_LOW); end
        checks++; if (dout !== 8'hE7) begin failures++; $display("FAIL sel2_dout: got %h expected e7", dout); end
        do_xfer(1'b0, 1'b0, 1'b0, 3'd5, 8'h11, 8'h5A,
                cs_low, rises, dones, cs_and, dout, srx, mf, sb, sa, bd, ba);
        checks++; if (cs_and !== 4'hF || cs_low !== 0) begin failures++; $display("FAIL sel5_cs: got %b/%0d expected 1111/0", cs_and, cs_low); end
        checks++; if (dones !== 1) begin failures++; $display("FAIL sel5_done: got %0d expected 1", dones); end
        checks++; if (dout !== 8'h5A) begin failures++; $display("FAIL sel5_dout: got %h expected 5a", dout); end
        checks++; if (rises !== DW) begin failures++; $display("FAIL sel5_rises: got %0d expected %0d", rises, DW); end
    endtask

    task automatic test_start_ignore();
        int cyc, dn;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; slave_sel = 3'd1; data_in = 8'h96;
        repeat (2) @(negedge clk);
        arm_slave(1'b0, 1'b0, 1'b0, 8'h69);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; dn = 0;
        while (dn == 0 && cyc < 200) begin
            start = (cyc == 10);
            if (cyc == 12) begin
                data_in = 8'h00; slave_sel = 3'd0; cpha = 1'b1; lsb_first = 1'b1;
            end
            if (done === 1'b1) dn++;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        s_act = 1'b0;
        checks++; if (cyc !== CS_LOW) begin failures++; $display("FAIL ign_latency: got %0d expected %0d", cyc, CS_LOW); end
        checks++; if (data_out !== 8'h69) begin failures++; $display("FAIL ign_dout: got %h expected 69", data_out); end
        checks++; if (s_rx !== 8'h96) begin failures++; $display("FAIL ign_slave_rx: got %h expected 96", s_rx); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0 || CS !== 4'hF) begin failures++; $display("FAIL ign_done_cycle_start: got busy=%b cs=%b expected 0/1111", busy, CS); end
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1 || busy === 1'b1) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL ign_extra_activity: got %0d expected 0", dn); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; slave_sel = 3'd1; data_in = 8'hC3;
        repeat (2) @(negedge clk);
        arm_slave(1'b0, 1'b0, 1'b0, 8'h5A);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        s_act = 1'b0;
        checks++; if (done !== 1'b1 || data_out !== 8'h5A) begin failures++; $display("FAIL b2b_first: got done=%b dout=%h expected 1/5a", done, data_out); end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || CS !== 4'b1101) begin failures++; $display("FAIL b2b_accept: got busy=%b cs=%b expected 1/1101", busy, CS); end
        cyc = 0;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== CS_LOW) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, CS_LOW); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL b2b_second_dout: got %h expected 00", data_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, dn;
        int cs_low, rises, dones;
        logic [NS-1:0] cs_and;
        logic [DW-1:0] dout, srx;
        logic mf, sb, sa, bd, ba;
        do_xfer(1'b0, 1'b0, 1'b0, 3'd3, 8'h24, 8'hB1,
                cs_low, rises, dones, cs_and, dout, srx, mf, sb, sa, bd, ba);
        checks++; if (dout !== 8'hB1) begin failures++; $display("FAIL rstmid_pre_dout: got %h expected b1", dout); end
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; slave_sel = 3'd0; data_in = 8'hA5;
        repeat (2) @(negedge clk);
        arm_slave(1'b0, 1'b0, 1'b0, 8'h3C);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 0; cyc < 15; cyc++) @(negedge clk);
        checks++; if (CS !== 4'b1110 || busy !== 1'b1) begin failures++; $display("FAIL rstmid_active: got cs=%b busy=%b expected 1110/1", CS, busy); end
        s_act = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (CS !== 4'hF || SCLK !== 1'b0) begin failures++; $display("FAIL rstmid_lines: got cs=%b sclk=%b expected 1111/0", CS, SCLK); end
        checks++; if (busy !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL rstmid_state: got busy=%b dout=%h expected 0/00", busy, data_out); end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) dn++;
        end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) dn++;
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d expected 0", dn); end
        do_xfer(1'b0, 1'b0, 1'b0, 3'd0, 8'hA5, 8'h3C,
                cs_low, rises, dones, cs_and, dout, srx, mf, sb, sa, bd, ba);
        checks++; if (dout !== 8'h3C || srx !== 8'hA5) begin failures++; $display("FAIL rstmid_after: got dout=%h srx=%h expected 3c/a5", dout, srx); end
        checks++; if (cs_low !== CS_LOW) begin failures++; $display("FAIL rstmid_after_cs_low: got %0d expected %0d", cs_low, CS_LOW); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_lsb_first();
        test_slave_sel();
        test_start_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
